// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit owning pc, halt status and retired count
module ctrl_sequencer #(
    parameter int OPCODE_WIDTH = 5,
    parameter int DEST_WIDTH   = 9,
    parameter int SRC1_WIDTH   = 9,
    parameter int SRC2_WIDTH   = 9,
    parameter int INSTR_WIDTH  = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int PC_WIDTH     = 16,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    imem_req,
    output logic [PC_WIDTH-1:0]     imem_addr,
    input  logic                    imem_ack,
    input  logic [INSTR_WIDTH-1:0]  imem_rdata,
    output logic [DEST_WIDTH-1:0]   rf_raddr1,
    output logic [SRC2_WIDTH-1:0]   rf_raddr2,
    input  logic [DATA_WIDTH-1:0]   rf_rdata1,
    input  logic [DATA_WIDTH-1:0]   rf_rdata2,
    output logic                    rf_we,
    output logic [DEST_WIDTH-1:0]   rf_waddr,
    output logic [1:0]              wb_sel,
    output logic                    alu_en,
    output logic [OPCODE_WIDTH-1:0] alu_op,
    output logic                    flags_we,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [SRC2_WIDTH-1:0]   dmem_addr,
    output logic [DATA_WIDTH-1:0]   dmem_wdata,
    input  logic                    dmem_ack,
    output logic                    halted,
    output logic                    illegal,
    output logic [CNT_WIDTH-1:0]    instret
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    localparam logic [OPCODE_WIDTH-1:0] OP_ALU_MAX = OPCODE_WIDTH'(17);
    localparam logic [OPCODE_WIDTH-1:0] OP_CMP     = OPCODE_WIDTH'(18);
    localparam logic [OPCODE_WIDTH-1:0] OP_NOP     = OPCODE_WIDTH'(19);
    localparam logic [OPCODE_WIDTH-1:0] OP_LOADI   = OPCODE_WIDTH'(20);
    localparam logic [OPCODE_WIDTH-1:0] OP_STORE   = OPCODE_WIDTH'(21);
    localparam logic [OPCODE_WIDTH-1:0] OP_MOV     = OPCODE_WIDTH'(22);
    localparam logic [OPCODE_WIDTH-1:0] OP_J       = OPCODE_WIDTH'(23);
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ     = OPCODE_WIDTH'(24);
    localparam logic [OPCODE_WIDTH-1:0] OP_HLT     = OPCODE_WIDTH'(25);

    state_t                  state, state_next;
    logic [INSTR_WIDTH-1:0]  ir;
    logic [PC_WIDTH-1:0]     pc, pc_next, pc_inc, target;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [DEST_WIDTH-1:0]   dest;
    logic [SRC1_WIDTH-1:0]   src1;
    logic [SRC2_WIDTH-1:0]   src2;
    logic                    is_alu, is_store, retire, set_halt, set_illegal;

    assign opcode     = ir[OPCODE_WIDTH-1:0];
    assign dest       = ir[OPCODE_WIDTH +: DEST_WIDTH];
    assign src1       = ir[OPCODE_WIDTH+DEST_WIDTH +: SRC1_WIDTH];
    assign src2       = ir[OPCODE_WIDTH+DEST_WIDTH+SRC1_WIDTH +: SRC2_WIDTH];
    assign is_alu     = opcode != '0 && opcode <= OP_ALU_MAX;
    assign is_store   = opcode == OP_STORE;
    assign pc_inc     = pc + 1'b1;
    assign target     = PC_WIDTH'(src2);
    assign imem_addr  = pc;
    // BEQ compares dest against src1; everything else reads src1/src2
    assign rf_raddr1  = opcode == OP_BEQ ? dest : DEST_WIDTH'(src1);
    assign rf_raddr2  = opcode == OP_BEQ ? SRC2_WIDTH'(src1) : src2;
    assign rf_waddr   = dest;
    assign wb_sel     = opcode == OP_LOADI ? 2'd1 : opcode == OP_MOV ? 2'd2 : 2'd0;
    assign alu_op     = opcode;
    assign dmem_we    = dmem_req && is_store;
    assign dmem_addr  = is_store ? SRC2_WIDTH'(dest) : src2;
    assign dmem_wdata = rf_rdata1;

    always_comb begin
        state_next  = state;
        pc_next     = pc;
        retire      = 1'b0;
        set_halt    = 1'b0;
        set_illegal = 1'b0;
        imem_req    = 1'b0;
        alu_en      = 1'b0;
        flags_we    = 1'b0;
        dmem_req    = 1'b0;
        rf_we       = 1'b0;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) state_next = DECODE;
            end
            DECODE: state_next = EXEC;
            EXEC: begin
                if (is_alu) begin
                    alu_en     = 1'b1;
                    state_next = WB;
                end else if (opcode == OP_CMP || opcode == OP_NOP) begin
                    alu_en     = opcode == OP_CMP;
                    flags_we   = opcode == OP_CMP;
                    retire     = 1'b1;
                    pc_next    = pc_inc;
                    state_next = FETCH;
                end else if (opcode == OP_LOADI || is_store) begin
                    state_next = MEM;
                end else if (opcode == OP_MOV) begin
                    state_next = WB;
                end else if (opcode == OP_J || opcode == OP_BEQ) begin
                    retire     = 1'b1;
                    pc_next    = opcode == OP_J || rf_rdata1 == rf_rdata2 ? target : pc_inc;
                    state_next = FETCH;
                end else begin
                    retire      = opcode == OP_HLT;
                    set_halt    = 1'b1;
                    set_illegal = opcode != OP_HLT;
                    state_next  = HALT;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    retire     = is_store;
                    pc_next    = is_store ? pc_inc : pc;
                    state_next = is_store ? FETCH : WB;
                end
            end
            WB: begin
                rf_we      = 1'b1;
                retire     = 1'b1;
                pc_next    = pc_inc;
                state_next = FETCH;
            end
            default: ;
        endcase
        // reset must silence strobes immediately, not one cycle later
        if (!rst) begin
            imem_req = 1'b0;
            alu_en   = 1'b0;
            flags_we = 1'b0;
            dmem_req = 1'b0;
            rf_we    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= FETCH;
            pc      <= '0;
            ir      <= '0;
            instret <= '0;
            halted  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            halted  <= halted | set_halt;
            illegal <= illegal | set_illegal;
            if (state == FETCH && imem_ack) ir <= imem_rdata;
            if (retire) instret <= instret + 1'b1;
        end
    end
endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: table-driven and hand-sequenced self-checking bench with a fetch-to-fetch scoreboard
module tb_ctrl_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] rf_rdata1 = '0, rf_rdata2 = '0;
    logic        dmem_ack = 1'b0;

    logic        imem_req, rf_we, alu_en, flags_we, dmem_req, dmem_we, halted, illegal;
    logic [15:0] imem_addr;
    logic [8:0]  rf_raddr1, rf_raddr2, rf_waddr, dmem_addr;
    logic [1:0]  wb_sel;
    logic [4:0]  alu_op;
    logic [31:0] dmem_wdata, instret;

    logic        w_imem_req, w_rf_we, w_alu_en, w_flags_we, w_dmem_req, w_dmem_we, w_halted, w_illegal;
    logic [8:0]  w_imem_addr;
    logic [8:0]  w_rf_raddr1, w_rf_raddr2, w_rf_waddr, w_dmem_addr;
    logic [1:0]  w_wb_sel;
    logic [4:0]  w_alu_op;
    logic [31:0] w_dmem_wdata, w_instret;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ctrl_sequencer dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1),
        .rf_rdata2(rf_rdata2), .rf_we(rf_we), .rf_waddr(rf_waddr), .wb_sel(wb_sel), .alu_en(alu_en),
        .alu_op(alu_op), .flags_we(flags_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .halted(halted),
        .illegal(illegal), .instret(instret)
    );

    // narrow-pc copy sharing all stimulus, used to observe pc wrap-around cheaply
    ctrl_sequencer #(.PC_WIDTH(9)) dut_w (
        .clk(clk), .rst(rst), .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .rf_raddr1(w_rf_raddr1), .rf_raddr2(w_rf_raddr2), .rf_rdata1(rf_rdata1),
        .rf_rdata2(rf_rdata2), .rf_we(w_rf_we), .rf_waddr(w_rf_waddr), .wb_sel(w_wb_sel), .alu_en(w_alu_en),
        .alu_op(w_alu_op), .flags_we(w_flags_we), .dmem_req(w_dmem_req), .dmem_we(w_dmem_we),
        .dmem_addr(w_dmem_addr), .dmem_wdata(w_dmem_wdata), .dmem_ack(dmem_ack), .halted(w_halted),
        .illegal(w_illegal), .instret(w_instret)
    );

    typedef struct packed {
        logic [4:0]  op;
        logic [8:0]  d, s1, s2;
        logic [31:0] d1, d2;
        logic [15:0] npc;
        logic [7:0]  lat;
        logic [3:0]  seen;
        logic [8:0]  ra1, ra2;
    } vec_t;

    typedef struct packed {
        logic [15:0] npc;
        logic [31:0] ret;
        logic [7:0]  lat;
        logic [3:0]  seen;
    } exp_t;

    vec_t tbl [10];
    exp_t sb [$];

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [8:0] d, input logic [8:0] s1, input logic [8:0] s2);
        return {s2, s1, d, op};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        chk("onehot", 32'($countones({rf_we, dmem_req, imem_req})), 32'($countones({rf_we, dmem_req, imem_req}) > 1 ? 1 : $countones({rf_we, dmem_req, imem_req})));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        rf_rdata1 = '0;
        rf_rdata2 = '0;
        repeat (3) tick();
        chk("rst_strobes", {imem_req, rf_we, alu_en, flags_we, dmem_req, dmem_we, halted, illegal}, 0);
        chk("rst_pc", imem_addr, 0);
        chk("rst_instret", instret, 0);
        chk("rst_dmem_wdata", dmem_wdata, 0);
        rst = 1'b1;
        #1;
        chk("rel_imem_req", imem_req, 1);
        chk("rel_imem_addr", imem_addr, 0);
    endtask

    task automatic issue(input logic [31:0] ins, input int cycles);
        imem_rdata = ins;
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        repeat (cycles - 1) tick();
    endtask

    initial begin
        int   n;
        logic [3:0] seen;
        logic any_req;
        exp_t e;
        int   exp_ret;
        tbl[0] = '{5'd19, 9'd1,    9'd2,  9'd3,    32'd0, 32'd0, 16'h0001, 8'd3, 4'b0000, 9'd2,  9'd3};
        tbl[1] = '{5'd1,  9'd4,    9'd5,  9'd6,    32'd0, 32'd0, 16'h0002, 8'd4, 4'b1001, 9'd5,  9'd6};
        tbl[2] = '{5'd18, 9'd7,    9'd8,  9'd9,    32'd0, 32'd0, 16'h0003, 8'd3, 4'b1100, 9'd8,  9'd9};
        tbl[3] = '{5'd22, 9'd10,   9'd11, 9'd12,   32'd0, 32'd0, 16'h0004, 8'd4, 4'b0001, 9'd11, 9'd12};
        tbl[4] = '{5'd23, 9'd1,    9'd2,  9'h030,  32'd0, 32'd0, 16'h0030, 8'd3, 4'b0000, 9'd2,  9'h030};
        tbl[5] = '{5'd24, 9'd3,    9'd4,  9'h020,  32'd7, 32'd7, 16'h0020, 8'd3, 4'b0000, 9'd3,  9'd4};
        tbl[6] = '{5'd24, 9'd3,    9'd4,  9'h020,  32'd7, 32'd8, 16'h0021, 8'd3, 4'b0000, 9'd3,  9'd4};
        tbl[7] = '{5'd20, 9'd5,    9'd6,  9'h040,  32'd0, 32'd0, 16'h0022, 8'd5, 4'b0011, 9'd6,  9'h040};
        tbl[8] = '{5'd21, 9'h041,  9'd7,  9'd8,    32'd0, 32'd0, 16'h0023, 8'd4, 4'b0010, 9'd7,  9'd8};
        tbl[9] = '{5'd17, 9'd9,    9'd10, 9'd11,   32'd0, 32'd0, 16'h0024, 8'd4, 4'b1001, 9'd10, 9'd11};

        do_reset();

        // ADDS with same-cycle ack
        imem_rdata = enc(5'd6, 9'd3, 9'd1, 9'd2);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("adds_ra1", rf_raddr1, 1);
        chk("adds_ra2", rf_raddr2, 2);
        chk("adds_c2_alu", alu_en, 0);
        tick();
        chk("adds_alu_en", alu_en, 1);
        chk("adds_alu_op", alu_op, 6);
        chk("adds_c3_we", rf_we, 0);
        tick();
        chk("adds_we", {rf_we, alu_en}, 2'b10);
        chk("adds_waddr", rf_waddr, 3);
        chk("adds_wb_sel", wb_sel, 0);
        tick();
        chk("adds_next_req", imem_req, 1);
        chk("adds_next_addr", imem_addr, 1);
        chk("adds_instret", instret, 1);

        // LOADI with dmem_ack three cycles late
        issue(enc(5'd20, 9'd5, 9'd0, 9'h040), 3);
        for (int i = 0; i < 4; i++) begin
            chk("ld_req", {dmem_req, dmem_we}, 2'b10);
            chk("ld_addr", dmem_addr, 9'h040);
            if (i == 3) dmem_ack = 1'b1;
            tick();
        end
        dmem_ack = 1'b0;
        chk("ld_we", rf_we, 1);
        chk("ld_wb_sel", wb_sel, 1);
        chk("ld_waddr", rf_waddr, 5);
        tick();
        chk("ld_next_addr", imem_addr, 2);
        chk("ld_instret", instret, 2);

        // table: each record runs fetch-to-fetch, checked through the scoreboard
        do_reset();
        exp_ret = 0;
        for (int k = 0; k < 10; k++) begin
            chk("tbl_fetch_req", imem_req, 1);
            imem_rdata = enc(tbl[k].op, tbl[k].d, tbl[k].s1, tbl[k].s2);
            imem_ack = 1'b1;
            dmem_ack = 1'b1;
            rf_rdata1 = tbl[k].d1;
            rf_rdata2 = tbl[k].d2;
            exp_ret++;
            sb.push_back('{tbl[k].npc, 32'(exp_ret), tbl[k].lat, tbl[k].seen});
            seen = '0;
            n = 1;
            tick();
            imem_ack = 1'b0;
            while (!imem_req && n < 20) begin
                if (n == 1) begin
                    chk("tbl_ra1", rf_raddr1, tbl[k].ra1);
                    chk("tbl_ra2", rf_raddr2, tbl[k].ra2);
                end
                seen |= {alu_en, flags_we, dmem_req, rf_we};
                n++;
                tick();
            end
            e = sb.pop_front();
            chk("tbl_latency", n, e.lat);
            chk("tbl_next_pc", imem_addr, e.npc);
            chk("tbl_instret", instret, e.ret);
            chk("tbl_strobes", seen, e.seen);
        end
        dmem_ack = 1'b0;

        // HLT is absorbing and retires
        issue(enc(5'd25, 9'd0, 9'd0, 9'd0), 3);
        chk("hlt_status", {halted, illegal}, 2'b10);
        chk("hlt_instret", instret, 11);
        any_req = 1'b0;
        imem_ack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            any_req |= imem_req | dmem_req | rf_we | alu_en;
            tick();
        end
        imem_ack = 1'b0;
        chk("hlt_quiet", any_req, 0);

        // reserved opcode halts without retiring
        do_reset();
        issue(enc(5'd19, 9'd0, 9'd0, 9'd0), 3);
        issue(enc(5'd27, 9'd0, 9'd0, 9'd0), 3);
        chk("ill_status", {halted, illegal}, 2'b11);
        chk("ill_instret", instret, 1);
        chk("ill_pc", imem_addr, 1);

        // reset mid-MEM aborts the access
        do_reset();
        issue(enc(5'd19, 9'd0, 9'd0, 9'd0), 3);
        issue(enc(5'd21, 9'h041, 9'd0, 9'd0), 3);
        chk("st_req", {dmem_req, dmem_we}, 2'b11);
        chk("st_addr", dmem_addr, 9'h041);
        rst = 1'b0;
        tick();
        chk("abort_dmem_req", {dmem_req, imem_req}, 0);
        chk("abort_pc", imem_addr, 0);
        chk("abort_instret", instret, 0);
        rst = 1'b1;
        #1;
        chk("abort_rel_req", imem_req, 1);

        // pc wrap: the 9-bit pc copy wraps 0x1FF -> 0 on NOP
        issue(enc(5'd23, 9'd0, 9'd0, 9'h1FF), 3);
        chk("wrap_j", w_imem_addr, 9'h1FF);
        chk("wrap_j_wide", imem_addr, 16'h01FF);
        issue(enc(5'd19, 9'd0, 9'd0, 9'd0), 3);
        chk("wrap_nop", w_imem_addr, 0);
        chk("wrap_nop_wide", imem_addr, 16'h0200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
